// File: rtl/core_memory_arbiter_pkg.sv
// Shared definitions for the core memory arbiter: FSM states, grant identifiers
// and small address helpers.
package core_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_BUSY_FETCH = 2'd1,
        ST_BUSY_DATA  = 2'd2,
        ST_DONE       = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } arb_grant_e;

    localparam logic [3:0] FETCH_BYTE_SEL = 4'b1111;

    // Fetch addresses are byte addresses; the memory port only sees words.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/core_memory_arbiter_if.sv
// Bundle of the fetch, load/store and shared memory port signals of the arbiter.
interface core_memory_arbiter_if;

    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic [31:0] fetchData;
    logic        fetchDone;
    logic        fetchError;

    logic        dataEnable;
    logic        dataWriteEnable;
    logic [3:0]  dataByteSelect;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic [31:0] dataReadData;
    logic        dataDone;
    logic        dataError;

    logic        memEnable;
    logic        memWriteEnable;
    logic [3:0]  memByteSelect;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memAck;

    // Arbiter side.
    modport slave (
        input  fetchRequest, fetchAddress,
        output fetchData, fetchDone, fetchError,
        input  dataEnable, dataWriteEnable, dataByteSelect, dataAddress, dataWriteData,
        output dataReadData, dataDone, dataError,
        output memEnable, memWriteEnable, memByteSelect, memAddress, memWriteData,
        input  memReadData, memAck
    );

    // Requesters and memory model side.
    modport master (
        output fetchRequest, fetchAddress,
        input  fetchData, fetchDone, fetchError,
        output dataEnable, dataWriteEnable, dataByteSelect, dataAddress, dataWriteData,
        input  dataReadData, dataDone, dataError,
        input  memEnable, memWriteEnable, memByteSelect, memAddress, memWriteData,
        output memReadData, memAck
    );

endinterface

// File: rtl/core_memory_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store traffic, with an optional per-transaction ack timeout.
module core_memory_arbiter
    import core_memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    core_memory_arbiter_if.slave  io_bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 32'd1;

    arb_state_e   r_state;
    arb_grant_e   r_last_grant;
    logic [CNT_W-1:0] r_cnt;
    logic         r_block_fetch;
    logic         r_block_data;
    logic [31:0]  r_fetch_data;
    logic         r_fetch_done;
    logic         r_fetch_err;
    logic [31:0]  r_data_rdata;
    logic         r_data_done;
    logic         r_data_err;
    logic         r_mem_en;
    logic         r_mem_we;
    logic [3:0]   r_mem_be;
    logic [31:0]  r_mem_addr;
    logic [31:0]  r_mem_wdata;

    logic             w_fetch_elig;
    logic             w_data_elig;
    logic             w_grant_data;
    logic             w_is_data;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_timeout;

    // A requester whose Done just pulsed sits out one IDLE cycle.
    assign w_fetch_elig = io_bus.fetchRequest & ~r_block_fetch;
    assign w_data_elig  = io_bus.dataEnable & ~r_block_data;
    assign w_grant_data = w_data_elig & (~w_fetch_elig | (r_last_grant == GRANT_FETCH));
    assign w_is_data    = (r_state == ST_BUSY_DATA);
    assign w_cnt_next   = r_cnt + CNT_W'(1);
    assign w_timeout    = (TIMEOUT_CYCLES != 32'd0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    // Arbitration FSM with registered port and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GRANT_FETCH;
            r_cnt         <= '0;
            r_block_fetch <= 1'b0;
            r_block_data  <= 1'b0;
            r_fetch_data  <= 32'h0;
            r_fetch_done  <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_data_rdata  <= 32'h0;
            r_data_done   <= 1'b0;
            r_data_err    <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= 4'h0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_block_fetch <= 1'b0;
                    r_block_data  <= 1'b0;
                    r_cnt         <= '0;
                    if (w_grant_data) begin
                        r_state      <= ST_BUSY_DATA;
                        r_last_grant <= GRANT_DATA;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= io_bus.dataWriteEnable;
                        r_mem_be     <= io_bus.dataByteSelect;
                        r_mem_addr   <= io_bus.dataAddress;
                        r_mem_wdata  <= io_bus.dataWriteData;
                    end else if (w_fetch_elig) begin
                        r_state      <= ST_BUSY_FETCH;
                        r_last_grant <= GRANT_FETCH;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_mem_be     <= FETCH_BYTE_SEL;
                        r_mem_addr   <= word_align(io_bus.fetchAddress);
                        r_mem_wdata  <= 32'h0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY_FETCH, ST_BUSY_DATA: begin
                    // An ack in the timeout cycle takes priority over the timeout.
                    if (io_bus.memAck || w_timeout) begin
                        r_state  <= ST_DONE;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (w_is_data) begin
                            r_data_done  <= 1'b1;
                            r_data_err   <= ~io_bus.memAck;
                            r_data_rdata <= (io_bus.memAck && !r_mem_we) ? io_bus.memReadData : 32'h0;
                        end else begin
                            r_fetch_done <= 1'b1;
                            r_fetch_err  <= ~io_bus.memAck;
                            r_fetch_data <= io_bus.memAck ? io_bus.memReadData : 32'h0;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                ST_DONE: begin
                    r_state       <= ST_IDLE;
                    r_block_fetch <= r_fetch_done;
                    r_block_data  <= r_data_done;
                    r_fetch_done  <= 1'b0;
                    r_fetch_err   <= 1'b0;
                    r_data_done   <= 1'b0;
                    r_data_err    <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.fetchData      = r_fetch_data;
    assign io_bus.fetchDone      = r_fetch_done;
    assign io_bus.fetchError     = r_fetch_err;
    assign io_bus.dataReadData   = r_data_rdata;
    assign io_bus.dataDone       = r_data_done;
    assign io_bus.dataError      = r_data_err;
    assign io_bus.memEnable      = r_mem_en;
    assign io_bus.memWriteEnable = r_mem_we;
    assign io_bus.memByteSelect  = r_mem_be;
    assign io_bus.memAddress     = r_mem_addr;
    assign io_bus.memWriteData   = r_mem_wdata;

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed self-checking bench for core_memory_arbiter (TIMEOUT_CYCLES = 4).
module tb_core_memory_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    core_memory_arbiter_if bus ();

    core_memory_arbiter #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_addr [4];
    logic [31:0] exp_rd   [4];
    logic        exp_dat  [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.fetchRequest    = 1'b0;
        bus.fetchAddress    = 32'h0;
        bus.dataEnable      = 1'b0;
        bus.dataWriteEnable = 1'b0;
        bus.dataByteSelect  = 4'h0;
        bus.dataAddress     = 32'h0;
        bus.dataWriteData   = 32'h0;
        bus.memReadData     = 32'h0;
        bus.memAck          = 1'b0;
        repeat (2) step();

        chk("rst_memEnable", {31'd0, bus.memEnable}, 32'd0);
        chk("rst_memAddress", bus.memAddress, 32'h0);
        chk("rst_fetchDone", {31'd0, bus.fetchDone}, 32'd0);
        chk("rst_dataReadData", bus.dataReadData, 32'h0);
        rst = 1'b1;

        // Single fetch, ack one cycle after grant.
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h0000_1004;
        step();
        chk("f_memEnable", {31'd0, bus.memEnable}, 32'd1);
        chk("f_memAddress", bus.memAddress, 32'h0000_1004);
        chk("f_memByteSelect", {28'd0, bus.memByteSelect}, 32'hF);
        chk("f_memWriteEnable", {31'd0, bus.memWriteEnable}, 32'd0);
        bus.memAck = 1'b1;
        bus.memReadData = 32'hDEAD_BEEF;
        step();
        chk("f_fetchDone", {31'd0, bus.fetchDone}, 32'd1);
        chk("f_fetchData", bus.fetchData, 32'hDEAD_BEEF);
        chk("f_fetchError", {31'd0, bus.fetchError}, 32'd0);
        chk("f_done_memEnable", {31'd0, bus.memEnable}, 32'd0);
        bus.memAck = 1'b0;
        bus.fetchRequest = 1'b0;
        step();
        chk("f_pulse_end", {31'd0, bus.fetchDone}, 32'd0);

        // Both requesters held high across four transactions.
        exp_addr[0] = 32'h0000_3000; exp_rd[0] = 32'h1111_0001; exp_dat[0] = 1'b1;
        exp_addr[1] = 32'h0000_1008; exp_rd[1] = 32'h2222_0002; exp_dat[1] = 1'b0;
        exp_addr[2] = 32'h0000_3000; exp_rd[2] = 32'h3333_0003; exp_dat[2] = 1'b1;
        exp_addr[3] = 32'h0000_1008; exp_rd[3] = 32'h4444_0004; exp_dat[3] = 1'b0;
        bus.fetchRequest    = 1'b1;
        bus.fetchAddress    = 32'h0000_1008;
        bus.dataEnable      = 1'b1;
        bus.dataWriteEnable = 1'b0;
        bus.dataByteSelect  = 4'hF;
        bus.dataAddress     = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr%0d_memEnable", i), {31'd0, bus.memEnable}, 32'd1);
            chk($sformatf("rr%0d_memAddress", i), bus.memAddress, exp_addr[i]);
            bus.memAck = 1'b1;
            bus.memReadData = exp_rd[i];
            step();
            bus.memAck = 1'b0;
            chk($sformatf("rr%0d_dataDone", i), {31'd0, bus.dataDone}, {31'd0, exp_dat[i]});
            chk($sformatf("rr%0d_fetchDone", i), {31'd0, bus.fetchDone}, {31'd0, ~exp_dat[i]});
            chk($sformatf("rr%0d_rdata", i), exp_dat[i] ? bus.dataReadData : bus.fetchData, exp_rd[i]);
            step();
            chk($sformatf("rr%0d_idle_memEnable", i), {31'd0, bus.memEnable}, 32'd0);
        end
        bus.fetchRequest = 1'b0;
        bus.dataEnable   = 1'b0;
        step();

        // Ack arriving in the timeout cycle completes normally.
        bus.dataEnable  = 1'b1;
        bus.dataAddress = 32'h0000_3100;
        step();
        step();
        step();
        step();
        chk("ta_busy4_memEnable", {31'd0, bus.memEnable}, 32'd1);
        bus.memAck = 1'b1;
        bus.memReadData = 32'h0000_55AA;
        step();
        bus.memAck = 1'b0;
        bus.dataEnable = 1'b0;
        chk("ta_dataDone", {31'd0, bus.dataDone}, 32'd1);
        chk("ta_dataError", {31'd0, bus.dataError}, 32'd0);
        chk("ta_dataReadData", bus.dataReadData, 32'h0000_55AA);
        step();
        step();

        // Timeout with request dropped mid-transaction.
        bus.dataEnable  = 1'b1;
        bus.dataAddress = 32'h0000_3200;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("to_busy%0d_memEnable", i), {31'd0, bus.memEnable}, 32'd1);
            if (i == 1) bus.dataEnable = 1'b0;
        end
        step();
        chk("to_dataDone", {31'd0, bus.dataDone}, 32'd1);
        chk("to_dataError", {31'd0, bus.dataError}, 32'd1);
        chk("to_dataReadData", bus.dataReadData, 32'h0);
        chk("to_memEnable", {31'd0, bus.memEnable}, 32'd0);
        step();
        chk("to_pulse_end", {31'd0, bus.dataError}, 32'd0);
        step();

        // Store: lanes and data pass through, captured read data is zero.
        bus.dataEnable      = 1'b1;
        bus.dataWriteEnable = 1'b1;
        bus.dataByteSelect  = 4'b1100;
        bus.dataWriteData   = 32'hAB00_0000;
        bus.dataAddress     = 32'h0000_2000;
        step();
        bus.dataWriteData = 32'h0;
        step();
        chk("st_memWriteEnable", {31'd0, bus.memWriteEnable}, 32'd1);
        chk("st_memByteSelect", {28'd0, bus.memByteSelect}, 32'hC);
        chk("st_memWriteData", bus.memWriteData, 32'hAB00_0000);
        chk("st_memAddress", bus.memAddress, 32'h0000_2000);
        bus.memAck = 1'b1;
        bus.memReadData = 32'h1234_5678;
        step();
        bus.memAck = 1'b0;
        bus.dataEnable = 1'b0;
        bus.dataWriteEnable = 1'b0;
        chk("st_dataDone", {31'd0, bus.dataDone}, 32'd1);
        chk("st_dataReadData", bus.dataReadData, 32'h0);
        chk("st_done_memWriteEnable", {31'd0, bus.memWriteEnable}, 32'd0);
        step();
        step();

        // Reset during BUSY_FETCH, then a fresh fetch with unaligned address.
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h0000_5000;
        step();
        chk("rb_memEnable", {31'd0, bus.memEnable}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rb_rst_memEnable", {31'd0, bus.memEnable}, 32'd0);
        chk("rb_rst_memAddress", bus.memAddress, 32'h0);
        chk("rb_rst_fetchData", bus.fetchData, 32'h0);
        chk("rb_rst_memByteSelect", {28'd0, bus.memByteSelect}, 32'h0);
        #2;
        rst = 1'b1;
        bus.fetchAddress = 32'h0000_2007;
        step();
        chk("rb_new_memAddress", bus.memAddress, 32'h0000_2004);
        chk("rb_new_memEnable", {31'd0, bus.memEnable}, 32'd1);
        bus.memAck = 1'b1;
        bus.memReadData = 32'hCAFE_F00D;
        step();
        bus.memAck = 1'b0;
        bus.fetchRequest = 1'b0;
        chk("rb_new_fetchDone", {31'd0, bus.fetchDone}, 32'd1);
        chk("rb_new_fetchData", bus.fetchData, 32'hCAFE_F00D);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/core_memory_arbiter.md
CORE_MEMORY_ARBITER -- requirements
Module: core_memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles a transaction may wait for memAck; 0 disables the timeout.
REQ-002 clk  input  1  core clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 fetchRequest  input  1  instruction fetch request, held until fetchDone.
REQ-005 fetchAddress  input  32  fetch byte address; bits [1:0] are ignored.
REQ-006 fetchData  output  32  fetched word, valid while fetchDone=1.
REQ-007 fetchDone  output  1  one-cycle completion pulse for fetch.
REQ-008 fetchError  output  1  qualifies fetchDone: the transaction timed out.
REQ-009 dataEnable  input  1  load/store request, held until dataDone.
REQ-010 dataWriteEnable  input  1  1=store, 0=load.
REQ-011 dataByteSelect  input  4  byte lanes.
REQ-012 dataAddress  input  32  word-aligned address.
REQ-013 dataWriteData  input  32  lane-aligned store data.
REQ-014 dataReadData  output  32  raw load word, valid while dataDone=1.
REQ-015 dataDone  output  1  one-cycle completion pulse for data.
REQ-016 dataError  output  1  qualifies dataDone: the transaction timed out.
REQ-017 memEnable / memWriteEnable  output  1 / 1  shared memory port request and write strobe.
REQ-018 memByteSelect  output  4  lanes; 4'b1111 for fetch.
REQ-019 memAddress / memWriteData  output  32 / 32  registered port address and data.
REQ-020 memReadData  input  32  read data, sampled when memAck=1.
REQ-021 memAck  input  1  transaction complete this cycle.

Function
REQ-022 States SHALL be IDLE, BUSY_FETCH, BUSY_DATA and DONE.
REQ-023 IDLE, only one eligible request: grant it; next state BUSY_FETCH or BUSY_DATA. Port outputs are registered from the granted inputs and valid from the next cycle.
REQ-024 IDLE, both requests eligible: grant data, unless the previous grant was data, then grant fetch. This gives round-robin and prevents fetch starvation.
REQ-025 In BUSY_*, memEnable SHALL be 1 and all port outputs SHALL hold stable.
REQ-026 memWriteEnable SHALL be 1 only in BUSY_DATA with the latched dataWriteEnable=1.
REQ-027 memAck=1 in BUSY_*: capture memReadData into the requester's data register and go to DONE; memEnable=0 in DONE.
REQ-028 DONE lasts exactly one cycle; the matching Done pulses and Error=0 in DONE; next state IDLE.
REQ-029 IDLE SHALL treat the requester whose Done pulsed in the previous cycle as ineligible for one cycle, so its still-high request is not re-granted.
REQ-030 DONE SHALL NOT grant; minimum request-to-Done latency is 2 cycles, and back-to-back transactions start every 3 cycles.
REQ-031 For stores, the captured read data SHALL be 32'h0.
REQ-032 A timeout counter SHALL clear on entry to BUSY_* and increment each BUSY cycle with memAck=0.
REQ-033 When the counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): go to DONE with Error=1 and data 32'h0. A memAck arriving in that same cycle wins, and the transaction completes normally.
REQ-034 A request dropped mid-transaction SHALL NOT abort it; Done still pulses.
REQ-035 Inputs of a non-granted requester SHALL be ignored.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, last-grant=fetch, counter 0, all outputs 0, and data registers 32'h0, including mid-transaction.
REQ-037 The first grant after reset release SHALL be decided by the REQ-024 rule.

Structure
REQ-038 State encoding and grant identifiers SHALL live in the shared core package.
REQ-039 TIMEOUT_CYCLES SHALL remain a module parameter.
REQ-040 The block SHALL be a single module with no sub-modules; the counter and FSM are too small to split.

Verification
REQ-041 Single fetch: fetchRequest with address 32'h0000_1004, memAck one cycle later with memReadData 32'hDEAD_BEEF -> memAddress 32'h0000_1004, byte select 4'hF, fetchData 32'hDEAD_BEEF with fetchDone pulse, latency 2 cycles.
REQ-042 Simultaneous fetch and data, continuously re-requested over 4 transactions -> grant order data, fetch, data, fetch; no repeated re-grant of a completed request.
REQ-043 Store: dataByteSelect 4'b1100, dataWriteData 32'hAB00_0000 at address 32'h2000 -> memWriteEnable=1 with matching outputs; dataDone pulse; dataReadData 32'h0.
REQ-044 Timeout with TIMEOUT_CYCLES=4 and memAck held 0 -> memEnable high for 4 cycles, then dataDone and dataError both high for one cycle, dataReadData 32'h0.
REQ-045 Reset asserted during BUSY_FETCH -> all outputs 0 that same cycle; after release, a new fetch completes normally.
